// File: rtl/data_mem_stage.sv
// data_mem_stage: memory-stage bus controller between the E->M and M->WB registers.
// Runs one req/ack transaction per load/store on a variable-latency data bus and
// raises stallM to freeze the upstream pipeline until the access completes.
// Optional feature: define DMEM_TIMEOUT_EN to abort BUSY after TIMEOUT cycles
// without ack (sticky mem_err, reads return 32'hDEADBEEF). Without it BUSY waits
// indefinitely and mem_err stays 0.
module data_mem_stage #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemReadM,
    input  logic              MemWriteM,
    input  logic [ADDR_W-1:0] ALUOutM,
    input  logic [DATA_W-1:0] WriteData,
    output logic [DATA_W-1:0] ReadData,
    output logic              stallM,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_ack,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              mem_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state_r;
    logic              access_s;
    logic              bus_req_r;
    logic              bus_we_r;
    logic [ADDR_W-1:0] bus_addr_r;
    logic [DATA_W-1:0] bus_wdata_r;
    logic [DATA_W-1:0] read_data_r;
    logic              mem_err_r;
    logic              stall_s;

    // Byte offset bits are irrelevant: only whole words are accessed.
    logic unused_addr_lsb_s;
    assign unused_addr_lsb_s = ^ALUOutM[1:0];

`ifdef DMEM_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
    logic [CNT_W-1:0] wait_cnt_r;
`else
    logic unused_timeout_s;
    assign unused_timeout_s = (TIMEOUT == 0);
`endif

    // Simultaneous read and write requests are treated as a write.
    assign access_s = MemReadM | MemWriteM;

    // Stall upstream while an access is being launched or is outstanding.
    always_comb begin
        stall_s = 1'b0;
        case (state_r)
            ST_IDLE: stall_s = access_s;
            ST_BUSY: stall_s = 1'b1;
            ST_DONE: stall_s = 1'b0;
            default: stall_s = 1'b0;
        endcase
    end

    // Transaction FSM with registered bus outputs and load result.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            bus_req_r   <= 1'b0;
            bus_we_r    <= 1'b0;
            bus_addr_r  <= {ADDR_W{1'b0}};
            bus_wdata_r <= {DATA_W{1'b0}};
            read_data_r <= {DATA_W{1'b0}};
            mem_err_r   <= 1'b0;
`ifdef DMEM_TIMEOUT_EN
            wait_cnt_r  <= {CNT_W{1'b0}};
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (access_s) begin
                        bus_addr_r  <= {ALUOutM[ADDR_W-1:2], 2'b00};
                        bus_wdata_r <= WriteData;
                        bus_we_r    <= MemWriteM;
                        bus_req_r   <= 1'b1;
                        state_r     <= ST_BUSY;
`ifdef DMEM_TIMEOUT_EN
                        wait_cnt_r  <= {CNT_W{1'b0}};
`endif
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    if (bus_ack) begin
                        // An ack on the timeout edge still completes normally.
                        if (!bus_we_r) begin
                            read_data_r <= bus_rdata;
                        end else begin
                            read_data_r <= read_data_r;
                        end
                        bus_req_r <= 1'b0;
                        state_r   <= ST_DONE;
`ifdef DMEM_TIMEOUT_EN
                    end else if (wait_cnt_r == TO_LAST) begin
                        if (!bus_we_r) begin
                            read_data_r <= DATA_W'(32'hDEAD_BEEF);
                        end else begin
                            read_data_r <= read_data_r;
                        end
                        bus_req_r <= 1'b0;
                        mem_err_r <= 1'b1;
                        state_r   <= ST_DONE;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + CNT_W'(1);
                        state_r    <= ST_BUSY;
                    end
`else
                    end else begin
                        state_r <= ST_BUSY;
                    end
`endif
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    bus_req_r <= 1'b0;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

    assign stallM    = stall_s;
    assign bus_req   = bus_req_r;
    assign bus_we    = bus_we_r;
    assign bus_addr  = bus_addr_r;
    assign bus_wdata = bus_wdata_r;
    assign ReadData  = read_data_r;
    assign mem_err   = mem_err_r;

endmodule

// File: tb/tb_data_mem_stage.sv
// Self-checking bench for data_mem_stage: directed vector table, hand-written
// corner sequences, and randomized transactions against a transaction-level model.
module tb_data_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemReadM;
    logic        MemWriteM;
    logic [31:0] ALUOutM;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        stallM;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        mem_err;

    int errors = 0;
    int checks = 0;

    // Model state: last value the M->WB register should have received.
    logic [31:0] model_read;

    data_mem_stage #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
        .clk(clk), .reset(reset),
        .MemReadM(MemReadM), .MemWriteM(MemWriteM),
        .ALUOutM(ALUOutM), .WriteData(WriteData),
        .ReadData(ReadData), .stallM(stallM),
        .bus_req(bus_req), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata),
        .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          delay;
        int          exp_stall;
        logic [31:0] exp_baddr;
        logic [31:0] exp_read;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Full access: called at posedge+1 with the DUT idle; returns at posedge+1, idle again.
    task automatic do_txn(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rdata,
                          input int delay, input int exp_stall,
                          input logic [31:0] exp_baddr, input logic [31:0] exp_read);
        int stalls;
        stalls    = 0;
        MemReadM  = rd;
        MemWriteM = wr;
        ALUOutM   = addr;
        WriteData = wdata;
        bus_ack   = 1'b0;
        #1;
        chk("req_before_launch", bus_req, 1'b0);
        if (stallM) stalls++;
        @(posedge clk); #1;
        for (int k = 0; k <= delay; k++) begin
            chk("req_busy", bus_req, 1'b1);
            chk("addr_busy", bus_addr, exp_baddr);
            chk("we_busy", bus_we, wr);
            if (wr) chk("wdata_busy", bus_wdata, wdata);
            bus_ack   = (k == delay);
            bus_rdata = (k == delay) ? rdata : $urandom;
            #1;
            if (stallM) stalls++;
            @(posedge clk); #1;
            bus_ack = 1'b0;
        end
        chk("req_done", bus_req, 1'b0);
        chk("stall_done", stallM, 1'b0);
        chk("readdata_done", ReadData, exp_read);
        chk("stall_cycles", 64'(stalls), 64'(exp_stall));
        @(posedge clk); #1;
    endtask

    // Idle cycle with a stray ack on the bus.
    task automatic idle_ack(input logic [31:0] rdata, input logic [31:0] exp_read);
        MemReadM  = 1'b0;
        MemWriteM = 1'b0;
        bus_ack   = 1'b1;
        bus_rdata = rdata;
        #1;
        chk("stall_idle_ack", stallM, 1'b0);
        @(posedge clk); #1;
        bus_ack = 1'b0;
        chk("readdata_idle_ack", ReadData, exp_read);
        chk("req_idle_ack", bus_req, 1'b0);
        chk("stall_after_idle_ack", stallM, 1'b0);
    endtask

`ifdef DMEM_TIMEOUT_EN
    // Access that never gets acked: TIMEOUT(4) BUSY cycles then abort.
    task automatic do_timeout(input logic rd, input logic wr, input logic [31:0] exp_read);
        int stalls;
        stalls    = 0;
        MemReadM  = rd;
        MemWriteM = wr;
        ALUOutM   = 32'h0000_0300;
        WriteData = 32'h0000_0011;
        bus_ack   = 1'b0;
        #1;
        if (stallM) stalls++;
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) begin
            chk("req_to_busy", bus_req, 1'b1);
            #1;
            if (stallM) stalls++;
            @(posedge clk); #1;
        end
        chk("req_to_done", bus_req, 1'b0);
        chk("stall_to_done", stallM, 1'b0);
        chk("readdata_to", ReadData, exp_read);
        chk("mem_err_to", mem_err, 1'b1);
        chk("stall_cycles_to", 64'(stalls), 64'(5));
        @(posedge clk); #1;
    endtask
`endif

    initial begin
        vec_t vecs[5];
        vecs[0] = '{1'b1, 1'b0, 32'h0000_0040, 32'h0000_0000, 32'h1234_5678, 0, 2, 32'h0000_0040, 32'h1234_5678};
        vecs[1] = '{1'b0, 1'b1, 32'h0000_0103, 32'hCAFE_F00D, 32'h0BAD_0BAD, 3, 5, 32'h0000_0100, 32'h1234_5678};
        vecs[2] = '{1'b1, 1'b1, 32'h0000_07FE, 32'h0000_55AA, 32'h0000_0BAD, 1, 3, 32'h0000_07FC, 32'h1234_5678};
        vecs[3] = '{1'b1, 1'b0, 32'h0000_0204, 32'h0000_0000, 32'hA5A5_0F0F, 2, 4, 32'h0000_0204, 32'hA5A5_0F0F};
        vecs[4] = '{1'b1, 1'b0, 32'h0000_0209, 32'h0000_0000, 32'h0000_0001, 0, 2, 32'h0000_0208, 32'h0000_0001};

        MemReadM  = 1'b0;
        MemWriteM = 1'b0;
        ALUOutM   = 32'h0;
        WriteData = 32'h0;
        bus_ack   = 1'b0;
        bus_rdata = 32'h0;
        reset     = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        chk("rst_req", bus_req, 1'b0);
        chk("rst_we", bus_we, 1'b0);
        chk("rst_addr", bus_addr, 32'h0);
        chk("rst_wdata", bus_wdata, 32'h0);
        chk("rst_readdata", ReadData, 32'h0);
        chk("rst_mem_err", mem_err, 1'b0);
        chk("rst_stall", stallM, 1'b0);
        reset = 1'b1;
        @(posedge clk); #1;
        model_read = 32'h0;

        // Stray ack right after reset must not capture data.
        idle_ack(32'hFFFF_FFFF, 32'h0);

`ifdef DMEM_TIMEOUT_EN
        // Ack on the same edge as the timeout completes without error.
        do_txn(1'b1, 1'b0, 32'h0000_0010, 32'h0, 32'h0000_ABCD, 3, 5, 32'h0000_0010, 32'h0000_ABCD);
        chk("mem_err_ack_wins", mem_err, 1'b0);
        model_read = 32'h0000_ABCD;
`endif

        // Directed table, including back-to-back loads (vecs[3], vecs[4]).
        for (int i = 0; i < 5; i++) begin
            do_txn(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].rdata,
                   vecs[i].delay, vecs[i].exp_stall, vecs[i].exp_baddr, vecs[i].exp_read);
        end
        model_read = 32'h0000_0001;

        // Reset asserted while BUSY drops bus_req at once.
        MemReadM = 1'b1;
        MemWriteM = 1'b0;
        ALUOutM  = 32'h0000_0500;
        #1;
        @(posedge clk); #1;
        chk("req_before_midreset", bus_req, 1'b1);
        #2 reset = 1'b0;
        #1;
        chk("req_midreset", bus_req, 1'b0);
        chk("readdata_midreset", ReadData, 32'h0);
        MemReadM = 1'b0;
        #1 reset = 1'b1;
        @(posedge clk); #1;
        chk("stall_after_midreset", stallM, 1'b0);
        chk("req_after_midreset", bus_req, 1'b0);
        model_read = 32'h0;
        do_txn(1'b1, 1'b0, 32'h0000_0604, 32'h0, 32'h7777_1111, 1, 3, 32'h0000_0604, 32'h7777_1111);
        model_read = 32'h7777_1111;

        // Randomized transactions checked against the transaction-level model.
        for (int n = 0; n < 40; n++) begin
            int          op;
            int          dly;
            logic [31:0] a;
            logic [31:0] wd;
            logic [31:0] rdv;
            logic        rd;
            logic        wr;
            op  = $urandom_range(0, 3);
            dly = $urandom_range(0, 5);
            a   = $urandom;
            wd  = $urandom;
            rdv = $urandom;
            rd  = (op == 1) || (op == 3);
            wr  = (op == 2) || (op == 3);
            if (op == 0) begin
                idle_ack(rdv, model_read);
            end else begin
                if (rd && !wr) model_read = rdv;
                do_txn(rd, wr, a, wd, rdv, dly, dly + 2, a & 32'hFFFF_FFFC, model_read);
            end
        end

`ifdef DMEM_TIMEOUT_EN
        do_timeout(1'b0, 1'b1, model_read);
        do_timeout(1'b1, 1'b0, 32'hDEAD_BEEF);
        do_txn(1'b1, 1'b0, 32'h0000_0020, 32'h0, 32'h0000_2222, 0, 2, 32'h0000_0020, 32'h0000_2222);
        chk("mem_err_sticky", mem_err, 1'b1);
        reset = 1'b0;
        #1;
        chk("mem_err_cleared", mem_err, 1'b0);
        reset = 1'b1;
`else
        chk("mem_err_tied", mem_err, 1'b0);
`endif

        MemReadM  = 1'b0;
        MemWriteM = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
